conv_sched_fsm: RTL and testbench
=================================

# conv_sched_fsm

Parametrised control FSM for the weight-stationary convolution datapath, generalising the fixed 2-beat, 5-stage controller. Operand beat count, write-back pipeline latency and address field widths are set at elaboration time. Feature-map and channel extents can be reduced at run time. The block adds abort, a `done` pulse and a pipeline-latency-driven drain. It sits between the external operand stream (valid/ready), the MAC datapath and the partial-sum memory.

## Interface
- `FEATURE_MAP_WIDTH`, 64: maximum x extent.
- `FEATURE_MAP_HEIGHT`, 64: maximum y extent.
- `INPUT_NB_CHANNELS`, 32: maximum input-channel extent.
- `OUTPUT_NB_CHANNELS`, 32: maximum output-channel extent.
- `OPERAND_BEATS`, 2: beats per weight load and per MAC point (≥1).
- `PIPE_LATENCY`, 5: cycles from an accepted beat to its write-back (≥1).
- Derived: `XW`, `YW`, `CW` = $clog2 of the width, height and output-channel maxima (min 1); `ADDR_WIDTH` = XW+YW+CW.
- `clk` in 1: clock; all logic is rising-edge.
- `rst_in` in 1: synchronous, active-high reset.
- `start` in 1: begin a run; sampled only in IDLE.
- `abort` in 1: cancel the run.
- `cfg_width`, `cfg_height`, `cfg_in_ch`, `cfg_out_ch` in 32 each: run extents, latched when `start` is accepted.
- `valid` in 1: operand beat present.
- `ready` out 1: beat accepted when `valid && ready`.
- `write_b` out OPERAND_BEATS: one-hot weight-register strobe.
- `write_a` out OPERAND_BEATS: one-hot activation-register strobe.
- `mac_valid`, `mac_accumulate_with_0` out 1: MAC fire, and clear-accumulator flag.
- `mem_re` out 1, `mem_read_addr` out ADDR_WIDTH: partial-sum read.
- `mem_we` out 1, `mem_write_addr` out ADDR_WIDTH: partial-sum write.
- `output_valid` out 1; `output_x`, `output_y`, `output_ch` out 32: final result and its coordinates, zero-extended.
- `running`, `done` out 1: run status and one-cycle completion pulse.

## Operation
- Config latch: a field of 0 or above its maximum is replaced by the maximum. Extents are E_w, E_h, E_i, E_o.
- Loop order, outermost first: ch_in, ch_out, x, y, beat. Weights are loaded once per (ch_in, ch_out) pair.
- States:
  - IDLE: `ready`=0, `running`=0. Goes to LOAD_W when `start`=1.
  - LOAD_W: `ready`=1, `write_b[beat]`=1. Beat increments on each handshake. The last beat goes to MAC with beat=0.
  - MAC: `ready`=1, `write_a[beat]`=1, `mac_valid`=handshake.
    - On the last-beat handshake, y advances; x, ch_out and ch_in cascade on wrap.
    - Last point overall → DRAIN.
    - Else if x and y were both last → LOAD_W.
    - Else stay in MAC.
  - DRAIN: `ready`=0. Lasts exactly PIPE_LATENCY cycles, counted down, then → DONE.
  - DONE: `done`=1 for one cycle, then → IDLE.
- Without a handshake, state, counters and strobes hold; `mac_valid` stays 0.
- `mac_accumulate_with_0` = `mac_valid` && ch_in==0 && beat==0.
- `mem_re` = `mac_valid` && beat==0 && ch_in≠0. `mem_read_addr` = {x, y, ch_out}.
- A last-beat handshake enters a PIPE_LATENCY-deep shift pipeline carrying the flag, x, y and ch_out.
  - At the pipeline output, `mem_we`=flag && ch_in was not last, with `mem_write_addr`={x, y, ch_out} of that point.
  - `output_valid`=flag && ch_in was last, with the coordinates on `output_*`.
- Abort: `abort`=1 in any non-IDLE state → IDLE next cycle. Counters and all pipeline flags clear, so no `mem_we` or `output_valid` after abort. `done` is not asserted.
- If `abort` and a handshake coincide, abort wins: no `mac_valid`, no pipeline entry.
- `rst_in`: every register is cleared, including the latched config. State → IDLE.

## Timing
- Reset values: every output is 0, including `ready`, `running` and `done`.
- `start` in cycle c → LOAD_W and `running`=1 in c+1.
- Strobes and `mac_valid` are combinational from state and `valid`, in the same cycle as the handshake.
- Write-back: `mem_we` / `output_valid` for a point assert exactly PIPE_LATENCY cycles after that point's last-beat handshake.
- Last handshake at cycle t: DRAIN spans t+1..t+L; the final `output_valid` is at t+L; DONE / `done` at t+L+1; IDLE at t+L+2.
- `start` arriving during the DONE cycle is ignored.

## Test plan
- Reset: assert `rst_in` 3 cycles with `valid`=1, `start`=1 → every output is 0 and state is IDLE.
- Full run, `valid` held at 1; defaults except W=H=2, IC=OC=2, beats=2, L=5, all cfg=0; `start` at c0:
  - 40 handshakes: 8 `write_b`, 32 `write_a`.
  - 8 `mem_re`, 8 `mem_we`, 8 `output_valid`.
  - First `output_valid` coordinates (0,0,0), then (0,1,0); `done` at c46.
- Same run with `valid` toggling every cycle → identical counts and address sequence. No strobe or `mac_valid` in any `valid`=0 cycle.
- Runtime config `cfg_width`=`cfg_height`=`cfg_in_ch`=`cfg_out_ch`=1 → 2 weight beats and 2 activation beats.
  - `mac_accumulate_with_0` on the first activation beat only.
  - 1 `output_valid` at (0,0,0); no `mem_we`, no `mem_re`; `done` at c10.
- Abort in the 5th MAC handshake cycle → IDLE next cycle; no further `mem_we` / `output_valid` / `done`. A new `start` then completes the full-run counts.
- `rst_in` mid-DRAIN → outputs 0 next cycle, no `done`, latched config cleared.

Source files
------------

// File: rtl/conv_sched_fsm.sv
// Sequencer for the weight-stationary conv datapath: operand beats,
// MAC fire, partial-sum read/write-back and run drain/completion.
module conv_sched_fsm #(
  parameter int FEATURE_MAP_WIDTH  = 64,
  parameter int FEATURE_MAP_HEIGHT = 64,
  parameter int INPUT_NB_CHANNELS  = 32,
  parameter int OUTPUT_NB_CHANNELS = 32,
  parameter int OPERAND_BEATS      = 2,
  parameter int PIPE_LATENCY       = 5,
  localparam int XW = (FEATURE_MAP_WIDTH > 1) ?
                      $clog2(FEATURE_MAP_WIDTH) : 1,
  localparam int YW = (FEATURE_MAP_HEIGHT > 1) ?
                      $clog2(FEATURE_MAP_HEIGHT) : 1,
  localparam int CW = (OUTPUT_NB_CHANNELS > 1) ?
                      $clog2(OUTPUT_NB_CHANNELS) : 1,
  localparam int ADDR_WIDTH = XW + YW + CW
) (
  input  logic                     clk,
  input  logic                     rst_in,
  input  logic                     start,
  input  logic                     abort,
  input  logic [31:0]              cfg_width,
  input  logic [31:0]              cfg_height,
  input  logic [31:0]              cfg_in_ch,
  input  logic [31:0]              cfg_out_ch,
  input  logic                     valid,
  output logic                     ready,
  output logic [OPERAND_BEATS-1:0] write_b,
  output logic [OPERAND_BEATS-1:0] write_a,
  output logic                     mac_valid,
  output logic                     mac_accumulate_with_0,
  output logic                     mem_re,
  output logic [ADDR_WIDTH-1:0]    mem_read_addr,
  output logic                     mem_we,
  output logic [ADDR_WIDTH-1:0]    mem_write_addr,
  output logic                     output_valid,
  output logic [31:0]              output_x,
  output logic [31:0]              output_y,
  output logic [31:0]              output_ch,
  output logic                     running,
  output logic                     done
);

  localparam int IW = (INPUT_NB_CHANNELS > 1) ?
                      $clog2(INPUT_NB_CHANNELS) : 1;
  localparam int BW = (OPERAND_BEATS > 1) ?
                      $clog2(OPERAND_BEATS) : 1;
  localparam int DW = (PIPE_LATENCY > 1) ?
                      $clog2(PIPE_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_MAC,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic          v;
    logic          lc;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] co;
  } wb_t;

  state_t        state;
  logic [BW-1:0] beat;
  logic [XW-1:0] x, lim_x;
  logic [YW-1:0] y, lim_y;
  logic [CW-1:0] co, lim_co;
  logic [IW-1:0] ci, lim_ci;
  logic [DW-1:0] drain_cnt;
  wb_t           pipe [PIPE_LATENCY];
  wb_t           entry;
  wb_t           tail;

  logic hs, last_beat, pt_done;
  logic x_last, y_last, co_last, ci_last;

  function automatic logic [31:0] clamp(
    input logic [31:0] v,
    input int unsigned mx
  );
    return (v == 32'd0 || v > mx) ? mx : v;
  endfunction

  assign ready     = (state == S_LOAD_W) || (state == S_MAC);
  assign running   = (state != S_IDLE);
  assign done      = (state == S_DONE) && !abort;
  assign hs        = valid && ready && !abort;
  assign last_beat = (beat == BW'(OPERAND_BEATS - 1));
  assign x_last    = (x == lim_x);
  assign y_last    = (y == lim_y);
  assign co_last   = (co == lim_co);
  assign ci_last   = (ci == lim_ci);

  assign write_b = (state == S_LOAD_W && hs) ?
                   (OPERAND_BEATS'(1) << beat) : '0;
  assign write_a = (state == S_MAC && hs) ?
                   (OPERAND_BEATS'(1) << beat) : '0;
  assign mac_valid = (state == S_MAC) && hs;
  assign pt_done   = mac_valid && last_beat;

  assign mac_accumulate_with_0 =
    mac_valid && (ci == '0) && (beat == '0);
  assign mem_re = mac_valid && (beat == '0) && (ci != '0);
  assign mem_read_addr = {x, y, co};

  always_comb begin
    entry    = '0;
    entry.v  = pt_done;
    entry.lc = ci_last;
    entry.x  = x;
    entry.y  = y;
    entry.co = co;
  end

  // Write-back is taken straight from the last pipeline register.
  assign tail         = pipe[PIPE_LATENCY-1];
  assign mem_we       = tail.v && !tail.lc;
  assign output_valid = tail.v && tail.lc;
  assign mem_write_addr =
    mem_we ? {tail.x, tail.y, tail.co} : '0;
  assign output_x  = output_valid ? 32'(tail.x)  : '0;
  assign output_y  = output_valid ? 32'(tail.y)  : '0;
  assign output_ch = output_valid ? 32'(tail.co) : '0;

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state     <= S_IDLE;
      beat      <= '0;
      x         <= '0;
      y         <= '0;
      co        <= '0;
      ci        <= '0;
      lim_x     <= '0;
      lim_y     <= '0;
      lim_co    <= '0;
      lim_ci    <= '0;
      drain_cnt <= '0;
      for (int i = 0; i < PIPE_LATENCY; i++)
        pipe[i] <= '0;
    end else if (abort && state != S_IDLE) begin
      state     <= S_IDLE;
      beat      <= '0;
      x         <= '0;
      y         <= '0;
      co        <= '0;
      ci        <= '0;
      drain_cnt <= '0;
      for (int i = 0; i < PIPE_LATENCY; i++)
        pipe[i] <= '0;
    end else begin
      pipe[0] <= entry;
      for (int i = 1; i < PIPE_LATENCY; i++)
        pipe[i] <= pipe[i-1];
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_LOAD_W;
            beat   <= '0;
            x      <= '0;
            y      <= '0;
            co     <= '0;
            ci     <= '0;
            lim_x  <= XW'(clamp(cfg_width,
                       FEATURE_MAP_WIDTH) - 32'd1);
            lim_y  <= YW'(clamp(cfg_height,
                       FEATURE_MAP_HEIGHT) - 32'd1);
            lim_ci <= IW'(clamp(cfg_in_ch,
                       INPUT_NB_CHANNELS) - 32'd1);
            lim_co <= CW'(clamp(cfg_out_ch,
                       OUTPUT_NB_CHANNELS) - 32'd1);
          end
        end
        S_LOAD_W: begin
          if (hs) begin
            if (last_beat) begin
              beat  <= '0;
              state <= S_MAC;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        S_MAC: begin
          if (hs) begin
            if (!last_beat) begin
              beat <= beat + 1'b1;
            end else begin
              beat <= '0;
              if (!y_last) begin
                y <= y + 1'b1;
              end else begin
                y <= '0;
                if (!x_last) begin
                  x <= x + 1'b1;
                end else begin
                  x <= '0;
                  if (!co_last) begin
                    co <= co + 1'b1;
                  end else begin
                    co <= '0;
                    ci <= ci_last ? '0 : ci + 1'b1;
                  end
                end
              end
              if (x_last && y_last && co_last && ci_last) begin
                state     <= S_DRAIN;
                drain_cnt <= DW'(PIPE_LATENCY - 1);
              end else if (x_last && y_last) begin
                state <= S_LOAD_W;
              end
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) state <= S_DONE;
          else drain_cnt <= drain_cnt - 1'b1;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_sched_fsm.sv
// Directed bench for conv_sched_fsm against a slot-list model
// of the run schedule and a due-cycle write-back queue.
module tb_conv_sched_fsm;

  localparam int L  = 5;
  localparam int NB = 2;
  localparam int MW = 2;
  localparam int MH = 2;
  localparam int MI = 2;
  localparam int MO = 2;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        start = 1'b1;
  logic        abort = 1'b0;
  logic        valid = 1'b1;
  logic [31:0] cfg_width = '0;
  logic [31:0] cfg_height = '0;
  logic [31:0] cfg_in_ch = '0;
  logic [31:0] cfg_out_ch = '0;
  logic        ready;
  logic [1:0]  write_b, write_a;
  logic        mac_valid, mac_accumulate_with_0;
  logic        mem_re, mem_we;
  logic [2:0]  mem_read_addr, mem_write_addr;
  logic        output_valid;
  logic [31:0] output_x, output_y, output_ch;
  logic        running, done;

  always #5 clk = ~clk;

  conv_sched_fsm #(
    .FEATURE_MAP_WIDTH(MW),
    .FEATURE_MAP_HEIGHT(MH),
    .INPUT_NB_CHANNELS(MI),
    .OUTPUT_NB_CHANNELS(MO),
    .OPERAND_BEATS(NB),
    .PIPE_LATENCY(L)
  ) dut (
    .clk(clk),
    .rst_in(rst_in),
    .start(start),
    .abort(abort),
    .cfg_width(cfg_width),
    .cfg_height(cfg_height),
    .cfg_in_ch(cfg_in_ch),
    .cfg_out_ch(cfg_out_ch),
    .valid(valid),
    .ready(ready),
    .write_b(write_b),
    .write_a(write_a),
    .mac_valid(mac_valid),
    .mac_accumulate_with_0(mac_accumulate_with_0),
    .mem_re(mem_re),
    .mem_read_addr(mem_read_addr),
    .mem_we(mem_we),
    .mem_write_addr(mem_write_addr),
    .output_valid(output_valid),
    .output_x(output_x),
    .output_y(output_y),
    .output_ch(output_ch),
    .running(running),
    .done(done)
  );

  typedef struct {
    bit act;
    int beat, x, y, co, ci;
  } slot_t;

  typedef struct {
    int due, x, y, co;
    bit fin;
  } wbq_t;

  slot_t slots[$];
  wbq_t  wq[$];
  int    phase = 0;
  int    k = 0;
  int    done_cyc = 0;
  int    cyc = 0;
  int    ei = 1;
  int    errors = 0;
  int    checks = 0;

  int rel_j, ev_at;
  int n_wb, n_wa, n_mv, n_re, n_we, n_ov, n_acc;
  int n_done, done_at, n_v0, n_after;
  int ov_q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic int clampx(input logic [31:0] v,
                                input int mx);
    return (v == 0 || v > mx) ? mx : int'(v);
  endfunction

  task automatic build_slots();
    int ew, eh, eo;
    ew = clampx(cfg_width, MW);
    eh = clampx(cfg_height, MH);
    ei = clampx(cfg_in_ch, MI);
    eo = clampx(cfg_out_ch, MO);
    slots.delete();
    for (int ci = 0; ci < ei; ci++)
      for (int co = 0; co < eo; co++) begin
        for (int b = 0; b < NB; b++)
          slots.push_back('{0, b, 0, 0, co, ci});
        for (int x = 0; x < ew; x++)
          for (int y = 0; y < eh; y++)
            for (int b = 0; b < NB; b++)
              slots.push_back('{1, b, x, y, co, ci});
      end
  endtask

  task automatic check_step();
    bit    hs;
    slot_t s;
    int    e_wb, e_wa, e_raddr, e_waddr;
    int    e_ox, e_oy, e_och;
    bit    e_mv, e_acc, e_re, e_we, e_ov, e_done;
    hs = 0; e_wb = 0; e_wa = 0; e_raddr = 0; e_waddr = 0;
    e_ox = 0; e_oy = 0; e_och = 0;
    e_mv = 0; e_acc = 0; e_re = 0; e_we = 0; e_ov = 0;
    s = '{0, 0, 0, 0, 0, 0};
    if (phase == 1) begin
      s = slots[k];
      hs = valid && !abort;
      e_raddr = s.x * 4 + s.y * 2 + s.co;
      if (hs && !s.act) e_wb = 1 << s.beat;
      if (hs && s.act) begin
        e_wa  = 1 << s.beat;
        e_mv  = 1;
        e_acc = (s.ci == 0) && (s.beat == 0);
        e_re  = (s.ci != 0) && (s.beat == 0);
      end
    end
    e_done = (phase == 2) && (cyc == done_cyc) && !abort;
    if (wq.size() > 0 && wq[0].due == cyc) begin
      e_we = !wq[0].fin;
      e_ov = wq[0].fin;
      if (e_we)
        e_waddr = wq[0].x * 4 + wq[0].y * 2 + wq[0].co;
      if (e_ov) begin
        e_ox = wq[0].x; e_oy = wq[0].y; e_och = wq[0].co;
      end
    end

    chk("ready", 32'(ready), 32'(phase == 1));
    chk("running", 32'(running), 32'(phase != 0));
    chk("write_b", 32'(write_b), e_wb);
    chk("write_a", 32'(write_a), e_wa);
    chk("mac_valid", 32'(mac_valid), 32'(e_mv));
    chk("acc_with_0", 32'(mac_accumulate_with_0), 32'(e_acc));
    chk("mem_re", 32'(mem_re), 32'(e_re));
    chk("mem_read_addr", 32'(mem_read_addr), e_raddr);
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_write_addr", 32'(mem_write_addr), e_waddr);
    chk("output_valid", 32'(output_valid), 32'(e_ov));
    chk("output_x", output_x, e_ox);
    chk("output_y", output_y, e_oy);
    chk("output_ch", output_ch, e_och);
    chk("done", 32'(done), 32'(e_done));

    if (write_b != 0) n_wb++;
    if (write_a != 0) n_wa++;
    if (mac_valid) n_mv++;
    if (mem_re) n_re++;
    if (mem_we) n_we++;
    if (mac_accumulate_with_0) n_acc++;
    if (output_valid) begin
      n_ov++;
      ov_q.push_back(output_x * 100 + output_y * 10 + output_ch);
    end
    if (done) begin
      n_done++;
      done_at = rel_j;
    end
    if (!valid && (write_a != 0 || write_b != 0 || mac_valid))
      n_v0++;
    if (rel_j > ev_at && (mem_we || output_valid || done))
      n_after++;

    if (rst_in) begin
      phase = 0;
      wq.delete();
    end else begin
      if (wq.size() > 0 && wq[0].due == cyc) void'(wq.pop_front());
      if (abort && phase != 0) begin
        phase = 0;
        wq.delete();
      end else if (phase == 0) begin
        if (start) begin
          build_slots();
          k = 0;
          phase = 1;
        end
      end else if (phase == 1) begin
        if (hs) begin
          if (s.act && s.beat == NB - 1)
            wq.push_back('{cyc + L, s.x, s.y, s.co, s.ci == ei - 1});
          k++;
          if (k == slots.size()) begin
            phase = 2;
            done_cyc = cyc + L + 1;
          end
        end
      end else if (cyc == done_cyc) begin
        phase = 0;
      end
    end
  endtask

  task automatic tick(input logic s, input logic v,
                      input logic a, input logic r);
    @(posedge clk);
    cyc++;
    #1;
    start = s; valid = v; abort = a; rst_in = r;
    #4;
    check_step();
  endtask

  task automatic run(input int vmode, input int abort_at,
                     input int rst_at, input int len);
    n_wb = 0; n_wa = 0; n_mv = 0; n_re = 0; n_we = 0;
    n_ov = 0; n_acc = 0; n_done = 0; done_at = -1;
    n_v0 = 0; n_after = 0;
    ov_q.delete();
    ev_at = (abort_at >= 0) ? abort_at : (rst_at >= 0 ? rst_at : len);
    for (int j = 0; j < len; j++) begin
      rel_j = j;
      tick(j == 0, (vmode == 0) || (j % 2 == 1),
           j == abort_at, j == rst_at);
    end
  endtask

  initial begin
    rel_j = 0; ev_at = 1000;
    // reset with start and valid held high
    #1;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 1'b1);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_running", 32'(running), 0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);

    // full run, valid always high
    run(0, -1, -1, 52);
    chk("full_wb", n_wb, 8);
    chk("full_wa", n_wa, 32);
    chk("full_re", n_re, 8);
    chk("full_we", n_we, 8);
    chk("full_ov", n_ov, 8);
    chk("full_done_at", done_at, 46);
    chk("full_ov0", (ov_q.size() > 0) ? ov_q[0] : -1, 0);
    chk("full_ov1", (ov_q.size() > 1) ? ov_q[1] : -1, 10);

    // valid toggling every cycle
    run(1, -1, -1, 92);
    chk("tog_wb", n_wb, 8);
    chk("tog_wa", n_wa, 32);
    chk("tog_re", n_re, 8);
    chk("tog_we", n_we, 8);
    chk("tog_ov", n_ov, 8);
    chk("tog_strobe_idle", n_v0, 0);
    chk("tog_done_at", done_at, 85);

    // reduced run-time extents
    cfg_width = 1; cfg_height = 1; cfg_in_ch = 1; cfg_out_ch = 1;
    run(0, -1, -1, 14);
    chk("cfg1_wb", n_wb, 2);
    chk("cfg1_wa", n_wa, 2);
    chk("cfg1_acc", n_acc, 1);
    chk("cfg1_ov", n_ov, 1);
    chk("cfg1_ov_coord", (ov_q.size() > 0) ? ov_q[0] : -1, 0);
    chk("cfg1_we", n_we, 0);
    chk("cfg1_re", n_re, 0);
    chk("cfg1_done_at", done_at, 10);
    cfg_width = 0; cfg_height = 0; cfg_in_ch = 0; cfg_out_ch = 0;

    // abort on the 5th MAC handshake, then a clean rerun
    run(0, 7, -1, 20);
    chk("abort_mv", n_mv, 4);
    chk("abort_after", n_after, 0);
    chk("abort_done", n_done, 0);
    run(0, -1, -1, 52);
    chk("rerun_wa", n_wa, 32);
    chk("rerun_we", n_we, 8);
    chk("rerun_ov", n_ov, 8);
    chk("rerun_done_at", done_at, 46);

    // reset in the middle of drain
    run(0, -1, 42, 56);
    chk("rstdrain_done", n_done, 0);
    chk("rstdrain_after", n_after, 0);
    chk("rstdrain_running", 32'(running), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
